pipelined_decode_stage: RTL and testbench

PIPELINED_DECODE_STAGE -- requirements
Module: pipelined_decode_stage

---
 rtl/pipelined_decode_stage_pkg.sv | 46 ++++
 rtl/pipelined_decode_stage_if.sv | 38 +++
 rtl/decode_fields.sv | 79 +++++++
 rtl/pipelined_decode_stage.sv | 143 ++++++++++++++
 tb/tb_pipelined_decode_stage.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/pipelined_decode_stage_pkg.sv
// Shared definitions for the decode stage: opcodes, field positions
// (bit 0 is the MSB of the instruction word), FSM states and small helpers.
package pipelined_decode_stage_pkg;

  localparam int INSTR_W = 32;

  localparam logic [5:0] OPC_ALU  = 6'b101010;
  localparam logic [5:0] OPC_LD   = 6'b100000;
  localparam logic [5:0] OPC_SD   = 6'b100001;
  localparam logic [5:0] OPC_BEZ  = 6'b100010;
  localparam logic [5:0] OPC_BNEZ = 6'b100011;
  localparam logic [5:0] OPC_NOP  = 6'b111100;

  localparam int FLD_OPC_FIRST   = 0;
  localparam int FLD_OPC_LAST    = 5;
  localparam int FLD_RD_FIRST    = 6;
  localparam int FLD_RD_LAST     = 10;
  localparam int FLD_RA_FIRST    = 11;
  localparam int FLD_RA_LAST     = 15;
  localparam int FLD_RB_FIRST    = 16;
  localparam int FLD_RB_LAST     = 20;
  localparam int FLD_PPP_FIRST   = 21;
  localparam int FLD_PPP_LAST    = 23;
  localparam int FLD_WW_FIRST    = 24;
  localparam int FLD_WW_LAST     = 25;
  localparam int FLD_ALUOP_FIRST = 26;
  localparam int FLD_ALUOP_LAST  = 31;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HELD  = 2'd1,
    ST_STALL = 2'd2
  } state_t;

  // ALU operations routed to the special-function unit.
  function automatic logic is_sfu_op(input logic [0:5] aluop);
    return aluop[1] | (aluop[0:4] == 5'b00111);
  endfunction

  // ALU operations that take no rB operand.
  function automatic logic alu_rb_unused(input logic [0:5] aluop);
    return (aluop == 6'b000100) | (aluop == 6'b000101) |
           (aluop == 6'b001101) | aluop[1];
  endfunction

endpackage

// File: rtl/pipelined_decode_stage_if.sv
// Handshake, decoded-output and writeback bundle of the decode stage.
interface pipelined_decode_stage_if #(
  parameter int REG_AW = 5,
  parameter int IMM_W  = 16
);
  import pipelined_decode_stage_pkg::*;

  logic                in_valid;
  logic                in_ready;
  logic [0:INSTR_W-1]  instruction;
  logic                flush;
  logic                out_valid;
  logic                out_ready;
  logic [REG_AW-1:0]   rA_address;
  logic [REG_AW-1:0]   rB_address;
  logic [REG_AW-1:0]   rD_address;
  logic [5:0]          alu_operation;
  logic [2:0]          ppp;
  logic [1:0]          ww;
  logic [IMM_W-1:0]    immediate_address;
  logic                alu, sfu, ld, sd, bez, bnez, nop, illegal;
  logic                wb_valid;
  logic [REG_AW-1:0]   wb_addr;

  modport slave (
    input  in_valid, instruction, flush, out_ready, wb_valid, wb_addr,
    output in_ready, out_valid, rA_address, rB_address, rD_address,
           alu_operation, ppp, ww, immediate_address,
           alu, sfu, ld, sd, bez, bnez, nop, illegal
  );

  modport master (
    output in_valid, instruction, flush, out_ready, wb_valid, wb_addr,
    input  in_ready, out_valid, rA_address, rB_address, rD_address,
           alu_operation, ppp, ww, immediate_address,
           alu, sfu, ld, sd, bez, bnez, nop, illegal
  );
endinterface

// File: rtl/decode_fields.sv
// Purely combinational field extraction and instruction classification.
module decode_fields
  import pipelined_decode_stage_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int IMM_W  = 16
) (
  input  logic [0:INSTR_W-1] instruction,
  output logic [REG_AW-1:0]  rA_address,
  output logic [REG_AW-1:0]  rB_address,
  output logic [REG_AW-1:0]  rD_address,
  output logic [5:0]         alu_operation,
  output logic [2:0]         ppp,
  output logic [1:0]         ww,
  output logic [IMM_W-1:0]   immediate_address,
  output logic               alu, sfu, ld, sd, bez, bnez, nop, illegal
);

  logic [0:5]       opc_s;
  logic [0:5]       aluop_s;
  logic [4:0]       rd_f_s, ra_f_s, rb_f_s;
  logic [2:0]       ppp_f_s;
  logic [1:0]       ww_f_s;
  logic [IMM_W-1:0] imm_f_s;

  assign opc_s   = instruction[FLD_OPC_FIRST:FLD_OPC_LAST];
  assign rd_f_s  = instruction[FLD_RD_FIRST:FLD_RD_LAST];
  assign ra_f_s  = instruction[FLD_RA_FIRST:FLD_RA_LAST];
  assign rb_f_s  = instruction[FLD_RB_FIRST:FLD_RB_LAST];
  assign ppp_f_s = instruction[FLD_PPP_FIRST:FLD_PPP_LAST];
  assign ww_f_s  = instruction[FLD_WW_FIRST:FLD_WW_LAST];
  assign aluop_s = instruction[FLD_ALUOP_FIRST:FLD_ALUOP_LAST];
  assign imm_f_s = instruction[INSTR_W-IMM_W:INSTR_W-1];

  // Decode by opcode; anything unlisted becomes an illegal no-op.
  always_comb begin
    rA_address        = '0;
    rB_address        = '0;
    rD_address        = '0;
    alu_operation     = 6'd0;
    ppp               = 3'd0;
    ww                = 2'd0;
    immediate_address = '0;
    {alu, sfu, ld, sd, bez, bnez, nop, illegal} = 8'd0;
    case (opc_s)
      OPC_ALU: begin
        rA_address    = REG_AW'(ra_f_s);
        rD_address    = REG_AW'(rd_f_s);
        rB_address    = alu_rb_unused(aluop_s) ? '0 : REG_AW'(rb_f_s);
        ppp           = ppp_f_s;
        ww            = ww_f_s;
        alu_operation = aluop_s;
        sfu           = is_sfu_op(aluop_s);
        alu           = ~is_sfu_op(aluop_s);
      end
      OPC_LD, OPC_SD: begin
        ld                = (opc_s == OPC_LD);
        sd                = (opc_s == OPC_SD);
        rD_address        = REG_AW'(rd_f_s);
        immediate_address = imm_f_s;
      end
      OPC_BEZ, OPC_BNEZ: begin
        bez               = (opc_s == OPC_BEZ);
        bnez              = (opc_s == OPC_BNEZ);
        rD_address        = REG_AW'(rd_f_s);
        rB_address        = REG_AW'(rd_f_s);
        immediate_address = imm_f_s;
      end
      OPC_NOP: begin
        nop = 1'b1;
      end
      default: begin
        nop     = 1'b1;
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/pipelined_decode_stage.sv
// Single-entry decode stage: registers the decoded word, holds it back while
// a source register is still pending, and tracks outstanding writes.
module pipelined_decode_stage
  import pipelined_decode_stage_pkg::*;
#(
  parameter int NUM_REGS      = 32,
  parameter int REG_AW        = $clog2(NUM_REGS),
  parameter int IMM_W         = 16,
  parameter int SCOREBOARD_EN = 1
) (
  input logic                      clk,
  input logic                      reset,
  pipelined_decode_stage_if.slave  bus
);

  localparam logic [NUM_REGS-1:0] ONE_C = {{(NUM_REGS-1){1'b0}}, 1'b1};

  state_t              state_r, state_next_s;
  logic [NUM_REGS-1:0] pending_r, pending_next_s, clr_mask_s, set_mask_s;
  logic                hazard_s, out_valid_s, in_ready_s, issue_s, accept_s;

  logic [REG_AW-1:0]   dec_ra_s, dec_rb_s, dec_rd_s;
  logic [5:0]          dec_aluop_s;
  logic [2:0]          dec_ppp_s;
  logic [1:0]          dec_ww_s;
  logic [IMM_W-1:0]    dec_imm_s;
  logic [7:0]          dec_flags_s;

  logic [REG_AW-1:0]   ra_r, rb_r, rd_r;
  logic [5:0]          aluop_r;
  logic [2:0]          ppp_r;
  logic [1:0]          ww_r;
  logic [IMM_W-1:0]    imm_r;
  logic                alu_r, sfu_r, ld_r, sd_r, bez_r, bnez_r, nop_r, illegal_r;

  decode_fields #(.REG_AW(REG_AW), .IMM_W(IMM_W)) u_decode (
    .instruction       (bus.instruction),
    .rA_address        (dec_ra_s),
    .rB_address        (dec_rb_s),
    .rD_address        (dec_rd_s),
    .alu_operation     (dec_aluop_s),
    .ppp               (dec_ppp_s),
    .ww                (dec_ww_s),
    .immediate_address (dec_imm_s),
    .alu               (dec_flags_s[7]),
    .sfu               (dec_flags_s[6]),
    .ld                (dec_flags_s[5]),
    .sd                (dec_flags_s[4]),
    .bez               (dec_flags_s[3]),
    .bnez              (dec_flags_s[2]),
    .nop               (dec_flags_s[1]),
    .illegal           (dec_flags_s[0])
  );

  // Held word is blocked when any register it reads is still pending.
  always_comb begin
    hazard_s = 1'b0;
    if (SCOREBOARD_EN == 32'sd0) begin
      hazard_s = 1'b0;
    end else if (alu_r || sfu_r) begin
      hazard_s = pending_r[ra_r] || ((rb_r != '0) && pending_r[rb_r]);
    end else if (sd_r || bez_r || bnez_r) begin
      hazard_s = pending_r[rd_r];
    end else begin
      hazard_s = 1'b0;
    end
  end

  // Handshake outputs and next state of the holding-register FSM.
  always_comb begin
    out_valid_s  = reset && !bus.flush && (state_r == ST_HELD) && !hazard_s;
    issue_s      = out_valid_s && bus.out_ready;
    in_ready_s   = reset && !bus.flush && ((state_r == ST_EMPTY) || issue_s);
    accept_s     = bus.in_valid && in_ready_s;
    state_next_s = state_r;
    if (bus.flush) begin
      state_next_s = ST_EMPTY;
    end else if (accept_s) begin
      state_next_s = ST_HELD;
    end else if (issue_s) begin
      state_next_s = ST_EMPTY;
    end else begin
      case (state_r)
        ST_EMPTY: state_next_s = ST_EMPTY;
        ST_HELD:  state_next_s = hazard_s ? ST_STALL : ST_HELD;
        ST_STALL: state_next_s = hazard_s ? ST_STALL : ST_HELD;
        default:  state_next_s = ST_EMPTY;
      endcase
    end
  end

  // An issued write sets its bit after the writeback clear, so the set wins.
  assign clr_mask_s = bus.wb_valid ? (ONE_C << bus.wb_addr) : '0;
  assign set_mask_s = (issue_s && (alu_r || sfu_r || ld_r) && (rd_r != '0))
                      ? (ONE_C << rd_r) : '0;
  assign pending_next_s = (SCOREBOARD_EN != 32'sd0)
                          ? (((pending_r & ~clr_mask_s) | set_mask_s) & ~ONE_C)
                          : '0;

  // FSM state and pending scoreboard registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r   <= ST_EMPTY;
      pending_r <= '0;
    end else begin
      state_r   <= state_next_s;
      pending_r <= pending_next_s;
    end
  end

  // Holding register for the decoded word, loaded only on accept.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ra_r <= '0; rb_r <= '0; rd_r <= '0;
      aluop_r <= 6'd0; ppp_r <= 3'd0; ww_r <= 2'd0; imm_r <= '0;
      {alu_r, sfu_r, ld_r, sd_r, bez_r, bnez_r, nop_r, illegal_r} <= 8'd0;
    end else if (accept_s) begin
      ra_r <= dec_ra_s; rb_r <= dec_rb_s; rd_r <= dec_rd_s;
      aluop_r <= dec_aluop_s; ppp_r <= dec_ppp_s; ww_r <= dec_ww_s;
      imm_r <= dec_imm_s;
      {alu_r, sfu_r, ld_r, sd_r, bez_r, bnez_r, nop_r, illegal_r} <= dec_flags_s;
    end
  end

  assign bus.in_ready          = in_ready_s;
  assign bus.out_valid         = out_valid_s;
  assign bus.rA_address        = ra_r;
  assign bus.rB_address        = rb_r;
  assign bus.rD_address        = rd_r;
  assign bus.alu_operation     = aluop_r;
  assign bus.ppp               = ppp_r;
  assign bus.ww                = ww_r;
  assign bus.immediate_address = imm_r;
  assign bus.alu               = alu_r;
  assign bus.sfu               = sfu_r;
  assign bus.ld                = ld_r;
  assign bus.sd                = sd_r;
  assign bus.bez               = bez_r;
  assign bus.bnez              = bnez_r;
  assign bus.nop               = nop_r;
  assign bus.illegal           = illegal_r;

endmodule

// File: tb/tb_pipelined_decode_stage.sv
// Scoreboard bench for pipelined_decode_stage: accepted words are queued, a
// negedge monitor checks handshakes, held outputs and pending bits against a
// word-level reference model.
module tb_pipelined_decode_stage;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  pipelined_decode_stage_if bus ();
  pipelined_decode_stage dut (.clk(clk), .reset(reset), .bus(bus));

  int tests_run = 0;
  int tests_failed = 0;

  logic [31:0] q[$];
  logic [31:0] pend_m = 32'd0;
  logic        hz_prev = 1'b0;
  logic        rst_prev_low = 1'b0;
  int          stall_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk(input int opc, input int rd, input int ra, input int rb,
                                     input int ppp, input int ww, input int aluop);
    return (32'(opc) << 26) | (32'(rd) << 21) | (32'(ra) << 16) | (32'(rb) << 11) |
           (32'(ppp) << 8) | (32'(ww) << 6) | 32'(aluop);
  endfunction

  function automatic int fopc(input logic [31:0] w); return int'((w >> 26) & 32'd63); endfunction
  function automatic int frd(input logic [31:0] w);  return int'((w >> 21) & 32'd31); endfunction
  function automatic int fra(input logic [31:0] w);  return int'((w >> 16) & 32'd31); endfunction
  function automatic int frb(input logic [31:0] w);  return int'((w >> 11) & 32'd31); endfunction
  function automatic int fal(input logic [31:0] w);  return int'(w & 32'd63); endfunction

  // rB is dropped for unary ALU ops and every op whose second aluop bit (from MSB) is set.
  function automatic int alu_rb(input logic [31:0] w);
    int al = fal(w);
    if (al == 4 || al == 5 || al == 13 || ((al >> 4) & 1) == 1) return 0;
    return frb(w);
  endfunction

  // Expected {rA,rB,rD,aluop,ppp,ww,imm,alu,sfu,ld,sd,bez,bnez,nop,illegal}.
  function automatic logic [49:0] model_dec(input logic [31:0] w);
    int opc = fopc(w);
    int al = fal(w);
    logic [4:0] ra = 5'd0, rb = 5'd0, rd = 5'd0;
    logic [5:0] aop = 6'd0;
    logic [2:0] p = 3'd0;
    logic [1:0] ww = 2'd0;
    logic [15:0] imm = 16'd0;
    logic [7:0] fl = 8'd0;
    if (opc == 42) begin
      ra = 5'(fra(w)); rd = 5'(frd(w)); rb = 5'(alu_rb(w));
      aop = 6'(al); p = 3'((w >> 8) & 32'd7); ww = 2'((w >> 6) & 32'd3);
      fl = (((al >> 4) & 1) == 1 || (al >> 1) == 7) ? 8'b0100_0000 : 8'b1000_0000;
    end else if (opc == 32 || opc == 33) begin
      rd = 5'(frd(w)); imm = w[15:0];
      fl = (opc == 32) ? 8'b0010_0000 : 8'b0001_0000;
    end else if (opc == 34 || opc == 35) begin
      rd = 5'(frd(w)); rb = 5'(frd(w)); imm = w[15:0];
      fl = (opc == 34) ? 8'b0000_1000 : 8'b0000_0100;
    end else if (opc == 60) begin
      fl = 8'b0000_0010;
    end else begin
      fl = 8'b0000_0011;
    end
    return {ra, rb, rd, aop, p, ww, imm, fl};
  endfunction

  function automatic logic model_hazard(input logic [31:0] w, input logic [31:0] p);
    int opc = fopc(w);
    if (opc == 42) return p[fra(w)] || (alu_rb(w) != 0 && p[alu_rb(w)]);
    if (opc == 33 || opc == 34 || opc == 35) return p[frd(w)];
    return 1'b0;
  endfunction

  function automatic logic [49:0] act_fields();
    return {bus.rA_address, bus.rB_address, bus.rD_address, bus.alu_operation, bus.ppp,
            bus.ww, bus.immediate_address, bus.alu, bus.sfu, bus.ld, bus.sd, bus.bez,
            bus.bnez, bus.nop, bus.illegal};
  endfunction

  function automatic logic [31:0] rand_word();
    int sel = $urandom_range(0, 9);
    int opc;
    int al;
    int specials[7] = '{4, 5, 13, 14, 16, 2, 31};
    case (sel)
      0, 1, 2: opc = 42;
      3: opc = 32;
      4: opc = 33;
      5: opc = 34;
      6: opc = 35;
      7: opc = 60;
      default: opc = $urandom_range(0, 63);
    endcase
    al = ($urandom_range(0, 1) == 0) ? specials[$urandom_range(0, 6)] : $urandom_range(0, 63);
    return mk(opc, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
              $urandom_range(0, 7), $urandom_range(0, 3), al);
  endfunction

  // Monitor: compare the cycle's observable behaviour with the model, then advance it.
  always @(negedge clk) begin
    logic present, hz, eov, eir;
    logic [31:0] nxt, iw;
    if (!reset) begin
      check("rst_in_ready", bus.in_ready, 64'd0);
      check("rst_out_valid", bus.out_valid, 64'd0);
      if (rst_prev_low) begin
        check("rst_fields", act_fields(), 64'd0);
        check("rst_pending", dut.pending_r, 64'd0);
      end
      q.delete();
      pend_m = 32'd0; hz_prev = 1'b0; stall_cnt = 0; rst_prev_low = 1'b1;
    end else begin
      rst_prev_low = 1'b0;
      present = (q.size() != 0);
      hz  = present ? model_hazard(q[0], pend_m) : 1'b0;
      eov = present && !hz && !hz_prev && !bus.flush;
      eir = !bus.flush && (!present || (eov && bus.out_ready));
      check("out_valid", bus.out_valid, eov);
      check("in_ready", bus.in_ready, eir);
      check("pending", dut.pending_r, pend_m);
      if (present) check("fields", act_fields(), model_dec(q[0]));
      nxt = pend_m;
      if (bus.wb_valid) nxt[bus.wb_addr] = 1'b0;
      if (bus.out_valid && bus.out_ready) begin
        if (present) begin
          iw = q.pop_front();
          if ((fopc(iw) == 42 || fopc(iw) == 32) && frd(iw) != 0) nxt[frd(iw)] = 1'b1;
        end else begin
          check("spurious_issue", bus.out_valid, 64'd0);
        end
        hz_prev = 1'b0; stall_cnt = 0;
      end else begin
        hz_prev = hz;
        stall_cnt = present ? stall_cnt + 1 : 0;
        if (stall_cnt > 300) begin
          tests_run++; tests_failed++;
          $display("FAIL issue_timeout: word %0h held %0d cycles, required issue", q[0], stall_cnt);
          stall_cnt = 0;
        end
      end
      if (bus.flush) begin
        q.delete(); hz_prev = 1'b0;
      end
      nxt[0] = 1'b0;
      pend_m = nxt;
    end
  end

  // One cycle of stimulus; an accepted word enters the scoreboard queue.
  task automatic step(input logic iv, input logic [31:0] w, input logic ordy,
                      input logic wbv, input int wba, input logic fl, input logic rs);
    @(posedge clk); #1;
    reset = rs; bus.in_valid = iv; bus.instruction = w; bus.out_ready = ordy;
    bus.wb_valid = wbv; bus.wb_addr = 5'(wba); bus.flush = fl;
    @(negedge clk); #1;
    if (reset && bus.in_valid && bus.in_ready) q.push_back(w);
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.instruction = 32'd0; bus.out_ready = 1'b0;
    bus.wb_valid = 1'b0; bus.wb_addr = 5'd0; bus.flush = 1'b0;
    repeat (3) step(1'b0, 32'd0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    // ALU writing r2, then a dependent ALU reading r2 presented back to back
    step(1'b1, 32'hA8432002, 1'b1, 1'b0, 0, 1'b0, 1'b1);
    step(1'b1, mk(42, 6, 2, 0, 0, 0, 2), 1'b1, 1'b0, 0, 1'b0, 1'b1);
    repeat (3) step(1'b0, 32'd0, 1'b1, 1'b0, 0, 1'b0, 1'b1);
    step(1'b0, 32'd0, 1'b1, 1'b1, 2, 1'b0, 1'b1);
    repeat (2) step(1'b0, 32'd0, 1'b1, 1'b0, 0, 1'b0, 1'b1);
    // undefined opcode naming pending r6 everywhere: issues without stalling
    step(1'b1, mk(0, 6, 6, 6, 1, 2, 3), 1'b1, 1'b0, 0, 1'b0, 1'b1);
    step(1'b0, 32'd0, 1'b1, 1'b0, 0, 1'b0, 1'b1);
    // held LD under back-pressure, then issue and accept in one cycle
    step(1'b1, mk(32, 6, 1, 1, 0, 0, 5), 1'b0, 1'b0, 0, 1'b0, 1'b1);
    repeat (3) step(1'b1, mk(42, 1, 0, 0, 0, 0, 0), 1'b0, 1'b0, 0, 1'b0, 1'b1);
    step(1'b1, mk(42, 1, 0, 0, 0, 0, 0), 1'b1, 1'b0, 0, 1'b0, 1'b1);
    step(1'b0, 32'd0, 1'b1, 1'b0, 0, 1'b0, 1'b1);
    // issue writing r5 with a simultaneous writeback of r5
    step(1'b1, mk(42, 5, 0, 0, 0, 0, 1), 1'b1, 1'b0, 0, 1'b0, 1'b1);
    step(1'b0, 32'd0, 1'b1, 1'b1, 5, 1'b0, 1'b1);
    step(1'b1, mk(42, 8, 5, 0, 0, 0, 1), 1'b1, 1'b0, 0, 1'b0, 1'b1);
    repeat (2) step(1'b0, 32'd0, 1'b0, 1'b0, 0, 1'b0, 1'b1);
    // flush while stalled
    step(1'b1, mk(42, 9, 0, 0, 0, 0, 0), 1'b0, 1'b0, 0, 1'b1, 1'b1);
    step(1'b0, 32'd0, 1'b1, 1'b0, 0, 1'b0, 1'b1);
    // BEZ on pending r5 stalls, then reset mid-stream
    step(1'b1, mk(34, 5, 0, 2, 3, 1, 9), 1'b1, 1'b0, 0, 1'b0, 1'b1);
    repeat (2) step(1'b0, 32'd0, 1'b1, 1'b0, 0, 1'b0, 1'b1);
    repeat (2) step(1'b1, rand_word(), 1'b1, 1'b0, 0, 1'b0, 1'b0);
    // randomized traffic with writebacks to keep the scoreboard draining
    for (int i = 0; i < 2000; i++) begin
      step(($urandom_range(0, 9) < 7), rand_word(), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 9) < 4), $urandom_range(0, 7), 1'b0, 1'b1);
    end
    repeat (4) step(1'b0, 32'd0, 1'b1, 1'b0, 0, 1'b0, 1'b1);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
